// File: rtl/bp_fe_ltb_update_sched.sv
// bp_fe_ltb_update_sched: queues branch-resolution updates and sequences them
// into the LTB write port. Updates are held while the LTB initialises, retried
// on a refused write, and LTB reads are throttled when issue is starved. A
// drain handshake lets the FE empty the queue before a redirect or flush.
//   upd_*       : update in (valid/ready)
//   ltb_*       : LTB write port out (valid/yumi), ltb_r_block_o read throttle
//   drain_*     : level request / one-cycle ack
//   busy_o, count_o : queue occupancy
// Optional statistics counters: define BP_FE_LTB_UPD_STATS_EN.
module bp_fe_ltb_update_sched #(
  parameter int vaddr_width_p  = 39,
  parameter int fifo_els_p     = 4,
  parameter int starve_limit_p = 8
`ifdef BP_FE_LTB_UPD_STATS_EN
 ,parameter int stat_width_p   = 16
`endif
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             ltb_init_done_i,
  input  logic                             upd_v_i,
  output logic                             upd_ready_o,
  input  logic                             upd_mispredict_i,
  input  logic                             upd_taken_i,
  input  logic [vaddr_width_p-1:0]         upd_addr_i,
  output logic                             ltb_w_v_o,
  output logic                             ltb_br_mispredict_o,
  output logic                             ltb_br_taken_o,
  output logic [vaddr_width_p-1:0]         ltb_br_src_addr_o,
  input  logic                             ltb_w_yumi_i,
  output logic                             ltb_r_block_o,
  input  logic                             drain_req_i,
  output logic                             drain_ack_o,
  output logic                             busy_o,
  output logic [$clog2(fifo_els_p+1)-1:0]  count_o
`ifdef BP_FE_LTB_UPD_STATS_EN
 ,output logic [stat_width_p-1:0]          stat_issued_o,
  output logic [stat_width_p-1:0]          stat_stall_o,
  output logic [stat_width_p-1:0]          stat_block_o
`endif
);

  localparam int cnt_w_lp = $clog2(fifo_els_p+1);
  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int stv_w_lp = $clog2(starve_limit_p+1);
  localparam logic [cnt_w_lp-1:0] els_lp   = cnt_w_lp'(fifo_els_p);
  localparam logic [stv_w_lp-1:0] limit_lp = stv_w_lp'(starve_limit_p);

  typedef struct packed {
    logic                     mispredict;
    logic                     taken;
    logic [vaddr_width_p-1:0] addr;
  } entry_s;

  typedef enum logic [1:0] {e_init, e_run, e_drain} state_e;

  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic [ptr_w_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [stv_w_lp-1:0]   starve_q, starve_d;
  logic                  block_q, block_d;
  logic                  ack_q, ack_d;
  entry_s                mem_q [fifo_els_p];
  entry_s                head;
  logic                  enq, deq, stall;

  // Reset gating keeps ready low while reset is held; otherwise ready is a
  // function of registered state only.
  assign upd_ready_o = reset_n_i & (count_q < els_lp) & (state_q != e_drain);
  assign ltb_w_v_o   = ((state_q == e_run) | (state_q == e_drain)) & (count_q != '0);
  assign enq         = upd_v_i & upd_ready_o;
  assign deq         = ltb_w_v_o & ltb_w_yumi_i;
  assign stall       = ltb_w_v_o & ~ltb_w_yumi_i;

  assign head                = mem_q[rptr_q];
  assign ltb_br_mispredict_o = head.mispredict;
  assign ltb_br_taken_o      = head.taken;
  assign ltb_br_src_addr_o   = head.addr;
  assign ltb_r_block_o       = block_q;
  assign drain_ack_o         = ack_q;
  assign busy_o              = (count_q != '0);
  assign count_o             = count_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    if (!ltb_init_done_i) begin
      state_d = e_init;
    end else begin
      case (state_q)
        e_init:  state_d = e_run;
        e_run:   if (drain_req_i) state_d = e_drain;
        e_drain: begin
          if (!drain_req_i) begin
            state_d = e_run;
          end else if (count_q == '0) begin
            state_d = e_run;
            ack_d   = 1'b1;
          end
        end
        default: state_d = e_init;
      endcase
    end
  end

  always_comb begin
    wptr_d  = enq ? wptr_q + ptr_w_lp'(1) : wptr_q;
    rptr_d  = deq ? rptr_q + ptr_w_lp'(1) : rptr_q;
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    starve_d = '0;
    if (stall) starve_d = (starve_q == limit_lp) ? starve_q : starve_q + stv_w_lp'(1);
    // Block is raised once a stall continues past a saturated counter, and
    // drops the cycle after any yumi or loss of valid.
    block_d = (starve_q == limit_lp) & stall;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_init;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      starve_q <= '0;
      block_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      starve_q <= starve_d;
      block_q  <= block_d;
      ack_q    <= ack_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= '{mispredict: upd_mispredict_i, taken: upd_taken_i, addr: upd_addr_i};
  end

`ifdef BP_FE_LTB_UPD_STATS_EN
  logic [stat_width_p-1:0] issued_q, issued_d, stall_q, stall_d, blk_q, blk_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    blk_d    = blk_q;
    if (deq     && issued_q != '1) issued_d = issued_q + stat_width_p'(1);
    if (stall   && stall_q  != '1) stall_d  = stall_q  + stat_width_p'(1);
    if (block_q && blk_q    != '1) blk_d    = blk_q    + stat_width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issued_q <= '0;
      stall_q  <= '0;
      blk_q    <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
      blk_q    <= blk_d;
    end
  end

  assign stat_issued_o = issued_q;
  assign stat_stall_o  = stall_q;
  assign stat_block_o  = blk_q;
`endif

endmodule

// File: tb/tb_bp_fe_ltb_update_sched.sv
module tb_bp_fe_ltb_update_sched;

  localparam int VA    = 39;
  localparam int ELS   = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_done;
  logic          upd_v;
  logic          upd_ready;
  logic          upd_mp;
  logic          upd_tk;
  logic [VA-1:0] upd_addr;
  logic          w_v;
  logic          br_mp;
  logic          br_tk;
  logic [VA-1:0] br_addr;
  logic          yumi;
  logic          r_block;
  logic          drain_req;
  logic          drain_ack;
  logic          busy;
  logic [2:0]    count;
`ifdef BP_FE_LTB_UPD_STATS_EN
  logic [15:0]   stat_issued, stat_stall, stat_block;
`endif

  bp_fe_ltb_update_sched #(
    .vaddr_width_p (VA),
    .fifo_els_p    (ELS),
    .starve_limit_p(LIMIT)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .ltb_init_done_i    (init_done),
    .upd_v_i            (upd_v),
    .upd_ready_o        (upd_ready),
    .upd_mispredict_i   (upd_mp),
    .upd_taken_i        (upd_tk),
    .upd_addr_i         (upd_addr),
    .ltb_w_v_o          (w_v),
    .ltb_br_mispredict_o(br_mp),
    .ltb_br_taken_o     (br_tk),
    .ltb_br_src_addr_o  (br_addr),
    .ltb_w_yumi_i       (yumi),
    .ltb_r_block_o      (r_block),
    .drain_req_i        (drain_req),
    .drain_ack_o        (drain_ack),
    .busy_o             (busy),
    .count_o            (count)
`ifdef BP_FE_LTB_UPD_STATS_EN
   ,.stat_issued_o      (stat_issued),
    .stat_stall_o       (stat_stall),
    .stat_block_o       (stat_block)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending updates in arrival order, operating mode, the
  // length of the current run of refused-issue cycles, and a pending ack.
  typedef enum {M_INIT, M_RUN, M_DRAIN} mode_e;
  logic [VA+1:0] sb_q[$];
  mode_e         mode     = M_INIT;
  int            stall_run = 0;
  bit            ack_pend = 0;
  bit            exp_ready, exp_wv;
  int            size0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_w_v",   64'(w_v),       0);
      chk("rst_ready", 64'(upd_ready), 0);
      chk("rst_ack",   64'(drain_ack), 0);
      chk("rst_busy",  64'(busy),      0);
      chk("rst_count", 64'(count),     0);
      chk("rst_block", 64'(r_block),   0);
      sb_q.delete();
      mode      = M_INIT;
      stall_run = 0;
      ack_pend  = 0;
    end else begin
      size0     = sb_q.size();
      exp_ready = (size0 < ELS) && (mode != M_DRAIN);
      exp_wv    = (mode != M_INIT) && (size0 != 0);
      chk("ready", 64'(upd_ready), 64'(exp_ready));
      chk("w_v",   64'(w_v),       64'(exp_wv));
      chk("busy",  64'(busy),      64'(size0 != 0));
      chk("count", 64'(count),     64'(size0));
      chk("block", 64'(r_block),   64'(stall_run >= LIMIT + 1));
      chk("ack",   64'(drain_ack), 64'(ack_pend));
      if (exp_wv) chk("payload", 64'({br_mp, br_tk, br_addr}), 64'(sb_q[0]));

      if (exp_wv && yumi) void'(sb_q.pop_front());
      if (upd_v && exp_ready) sb_q.push_back({upd_mp, upd_tk, upd_addr});

      if (exp_wv && !yumi) stall_run = (stall_run < 1000) ? stall_run + 1 : stall_run;
      else                 stall_run = 0;

      ack_pend = (mode == M_DRAIN) && init_done && drain_req && (size0 == 0);
      if (!init_done) mode = M_INIT;
      else case (mode)
        M_INIT:  mode = M_RUN;
        M_RUN:   if (drain_req) mode = M_DRAIN;
        M_DRAIN: if (!drain_req || size0 == 0) mode = M_RUN;
        default: mode = M_INIT;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mp, input logic tk, input logic [VA-1:0] a);
    upd_v = 1'b1; upd_mp = mp; upd_tk = tk; upd_addr = a;
    cyc();
    upd_v = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (drain_ack) seen = 1;
    end
    if (!seen) chk("drain_ack_timeout", 0, 1);
  endtask

  logic [63:0] rnd;
  int stall_burst = 0;
  int init_low    = 0;

  initial begin
    reset_n = 1'b0; init_done = 1'b0; upd_v = 1'b0; upd_mp = 1'b0; upd_tk = 1'b0;
    upd_addr = '0; yumi = 1'b0; drain_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Init hold: fill during init, then release with yumi always high.
    for (int i = 0; i < 4; i++) send(1'(i), ~1'(i), VA'(32'h100 + 4 * i));
    send(1'b1, 1'b1, VA'(32'h1F0));
    yumi = 1'b1; init_done = 1'b1;
    repeat (7) cyc();

    // Latency: single update into an empty queue.
    send(1'b1, 1'b0, VA'(32'h200));
    repeat (3) cyc();

    // Full queue with simultaneous dequeue and offered update.
    yumi = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, VA'(32'h300 + 4 * i));
    yumi = 1'b1;
    send(1'b1, 1'b1, VA'(32'h3F0));
    yumi = 1'b0;
    cyc();
    yumi = 1'b1;
    repeat (5) cyc();

    // Starvation.
    yumi = 1'b0;
    send(1'b0, 1'b0, VA'(32'h400));
    repeat (14) cyc();
    yumi = 1'b1;
    repeat (3) cyc();

    // Drain with 3 queued, then drain on an empty queue.
    yumi = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, VA'(32'h500 + 4 * i));
    drain_req = 1'b1; yumi = 1'b1;
    wait_ack(20);
    drain_req = 1'b0;
    repeat (2) cyc();
    drain_req = 1'b1;
    wait_ack(10);
    drain_req = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset mid-drain with 2 queued.
    yumi = 1'b0;
    send(1'b0, 1'b1, VA'(32'h600));
    send(1'b1, 1'b1, VA'(32'h604));
    drain_req = 1'b1;
    repeat (2) cyc();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_w_v",   64'(w_v),       0);
    chk("async_ack",   64'(drain_ack), 0);
    chk("async_count", 64'(count),     0);
    chk("async_busy",  64'(busy),      0);
    drain_req = 1'b0; init_done = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(1'b0, 1'b0, VA'(32'h700));
    repeat (4) cyc();
    init_done = 1'b1; yumi = 1'b1;
    repeat (3) cyc();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rnd      = {$urandom(), $urandom()};
      upd_v    = 1'($urandom_range(0, 1));
      upd_mp   = rnd[63];
      upd_tk   = rnd[62];
      upd_addr = rnd[VA-1:0];
      if (stall_burst == 0 && $urandom_range(0, 99) < 3) stall_burst = 12;
      if (stall_burst > 0) begin
        yumi = 1'b0;
        stall_burst--;
      end else begin
        yumi = ($urandom_range(0, 9) < 6);
      end
      if (init_low == 0 && $urandom_range(0, 199) == 0) init_low = $urandom_range(1, 5);
      if (init_low > 0) init_low--;
      init_done = (init_low == 0);
      if (!drain_req)               drain_req = ($urandom_range(0, 99) < 4);
      else if (drain_ack)           drain_req = 1'b0;
      else if ($urandom_range(0, 99) < 2) drain_req = 1'b0;
      cyc();
    end

    upd_v = 1'b0; drain_req = 1'b0; yumi = 1'b1; init_done = 1'b1;
    repeat (8) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
